// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared parameters and FSM state type for the BNN activation collector
package bnn_pkg;

    localparam int N_BITS_DEF = 8;
    localparam int CNT_W_DEF  = $clog2(N_BITS_DEF + 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/bnn_popcount.sv
// rtl/bnn_popcount.sv - combinational count of ones in an activation vector
module bnn_popcount #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = $clog2(N_BITS + 1)
) (
    input  logic [N_BITS-1:0] vec,
    output logic [CNT_W-1:0]  count
);

    // Plain adder chain over the vector bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < N_BITS; i++) begin
            count = count + CNT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/bnn_activation_collector.sv
// rtl/bnn_activation_collector.sv - packs serial binarised neuron bits into vectors with popcount/threshold decision
module bnn_activation_collector
    import bnn_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic [CNT_W-1:0]  thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] act_vec,
    output logic [CNT_W-1:0]  popcount,
    output logic              decision,
    output logic              overflow
);

    localparam int               IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_BITS - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [N_BITS-1:0]  shreg;
    logic [N_BITS-1:0]  vec_next;
    logic [N_BITS-1:0]  pc_vec;
    logic [CNT_W-1:0]   pc;
    logic               pc_ge;
    logic               held_dec;
    logic               drain;

    // Vector as it would look with the current bit written at its slot.
    always_comb begin
        vec_next = shreg;
        vec_next[cnt[IDX_W-1:0]] = bit_in;
    end

    // In HOLD the completed vector already sits in shreg; otherwise count the vector being completed.
    assign pc_vec = (state == HOLD) ? shreg : vec_next;
    assign pc_ge  = (pc >= thresh);
    assign drain  = out_valid && out_ready;

    bnn_popcount #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_popcount (
        .vec   (pc_vec),
        .count (pc)
    );

    // Collection FSM, output buffer and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            cnt       <= '0;
            shreg     <= '0;
            held_dec  <= 1'b0;
            out_valid <= 1'b0;
            act_vec   <= '0;
            popcount  <= '0;
            decision  <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= COLLECT;
            cnt       <= '0;
            shreg     <= '0;
            held_dec  <= 1'b0;
            out_valid <= 1'b0;
            act_vec   <= '0;
            popcount  <= '0;
            decision  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (drain) begin
                        out_valid <= 1'b0;
                    end
                    if (bit_valid) begin
                        shreg <= vec_next;
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (!out_valid || out_ready) begin
                                act_vec   <= vec_next;
                                popcount  <= pc;
                                decision  <= pc_ge;
                                out_valid <= 1'b1;
                            end else begin
                                // Threshold is captured now, not when the vector finally moves.
                                held_dec <= pc_ge;
                                state    <= HOLD;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bit_valid) begin
                        overflow <= 1'b1;
                    end
                    // out_valid is always high here, so out_ready alone completes the handshake.
                    if (out_ready) begin
                        act_vec  <= shreg;
                        popcount <= pc;
                        decision <= held_dec;
                        state    <= COLLECT;
                        cnt      <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_activation_collector.sv
// tb/tb_bnn_activation_collector.sv - randomized and directed self-checking bench for bnn_activation_collector
module tb_bnn_activation_collector;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       bit_valid;
    logic       bit_in;
    logic [3:0] thresh;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] act_vec;
    logic [3:0] popcount;
    logic       decision;
    logic       overflow;

    int n_tests;
    int n_fail;

    // reference model state
    logic [7:0] m_vec;
    logic [7:0] m_buf;
    logic [7:0] m_held;
    int         m_n;
    bit         m_valid;
    bit         m_hold;
    bit         m_ovf;
    int         m_pop;
    bit         m_dec;
    bit         m_hdec;

    bnn_activation_collector dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act_vec   (act_vec),
        .popcount  (popcount),
        .decision  (decision),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vec   = '0;
        m_buf   = '0;
        m_held  = '0;
        m_n     = 0;
        m_valid = 0;
        m_hold  = 0;
        m_ovf   = 0;
        m_pop   = 0;
        m_dec   = 0;
        m_hdec  = 0;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check_eq({tag, ".act_vec"},   32'(act_vec),   32'(m_buf));
        check_eq({tag, ".popcount"},  32'(popcount),  32'(m_pop));
        check_eq({tag, ".decision"},  32'(decision),  32'(m_dec));
        check_eq({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic bv, input logic b, input logic rdy,
                        input logic [3:0] th, input logic clr, input string tag);
        bit drain;
        bit dec;
        @(negedge clk);
        bit_valid = bv;
        bit_in    = b;
        out_ready = rdy;
        thresh    = th;
        clear     = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            drain = m_valid && rdy;
            if (m_hold) begin
                if (bv) m_ovf = 1;
                if (drain) begin
                    m_buf  = m_held;
                    m_pop  = $countones(m_held);
                    m_dec  = m_hdec;
                    m_hold = 0;
                end
            end else begin
                if (drain) m_valid = 0;
                if (bv) begin
                    m_vec[m_n] = b;
                    m_n++;
                    if (m_n == 8) begin
                        m_n = 0;
                        dec = ($countones(m_vec) >= int'(th));
                        if (!m_valid) begin
                            m_buf   = m_vec;
                            m_pop   = $countones(m_vec);
                            m_dec   = dec;
                            m_valid = 1;
                        end else begin
                            m_held = m_vec;
                            m_hdec = dec;
                            m_hold = 1;
                        end
                    end
                end
            end
        end
        #1;
        compare_all(tag);
    endtask

    task automatic send_vec(input logic [7:0] v, input logic rdy, input logic [3:0] th, input string tag);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, v[i], rdy, th, 1'b0, tag);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        bit_valid = 1'b0;
        clear     = 1'b0;
        rst       = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        thresh    = 4'd0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // bits 1,0,1,1,0,0,1,0 with thresh 4
        send_vec(8'h4D, 1'b1, 4'd4, "v4d_t4");
        check_eq("v4d_t4.valid_const", 32'(out_valid), 32'd1);
        check_eq("v4d_t4.vec_const", 32'(act_vec), 32'h4D);
        check_eq("v4d_t4.pop_const", 32'(popcount), 32'd4);
        check_eq("v4d_t4.dec_const", 32'(decision), 32'd1);
        step(1'b0, 1'b0, 1'b1, 4'd4, 1'b0, "drain1");

        send_vec(8'h4D, 1'b1, 4'd5, "v4d_t5");
        check_eq("v4d_t5.dec_const", 32'(decision), 32'd0);
        step(1'b0, 1'b0, 1'b1, 4'd5, 1'b0, "drain2");

        send_vec(8'h00, 1'b1, 4'd0, "v00_t0");
        check_eq("v00_t0.pop_const", 32'(popcount), 32'd0);
        check_eq("v00_t0.dec_const", 32'(decision), 32'd1);

        send_vec(8'hFF, 1'b1, 4'd9, "vff_t9");
        check_eq("vff_t9.dec_const", 32'(decision), 32'd0);
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, "drain3");

        // buffer full: 0xFF buffered, 0x0F held, extra bit dropped
        send_vec(8'hFF, 1'b0, 4'd2, "hold_a");
        send_vec(8'h0F, 1'b0, 4'd2, "hold_b");
        check_eq("hold.vec_const", 32'(act_vec), 32'hFF);
        step(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, "hold_extra");
        check_eq("hold.ovf_const", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, "hold_xfer");
        check_eq("hold.xfer_vec_const", 32'(act_vec), 32'h0F);
        check_eq("hold.xfer_pop_const", 32'(popcount), 32'd4);
        check_eq("hold.xfer_valid_const", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, "hold_drain");
        step(1'b0, 1'b0, 1'b0, 4'd2, 1'b1, "clr_ovf");

        // back-to-back 16 bits with continuous ready
        send_vec(8'h3C, 1'b1, 4'd4, "b2b_a");
        check_eq("b2b_a.vec_const", 32'(act_vec), 32'h3C);
        send_vec(8'hC1, 1'b1, 4'd4, "b2b_b");
        check_eq("b2b_b.vec_const", 32'(act_vec), 32'hC1);
        check_eq("b2b.ovf_const", 32'(overflow), 32'd0);
        step(1'b0, 1'b0, 1'b1, 4'd4, 1'b0, "b2b_drain");

        // reset mid-vector
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, "partial_rst");
        pulse_reset();
        send_vec(8'hA5, 1'b1, 4'd3, "after_rst");
        check_eq("after_rst.vec_const", 32'(act_vec), 32'hA5);
        step(1'b0, 1'b0, 1'b1, 4'd3, 1'b0, "drain4");

        // clear mid-vector, coincident with a valid bit
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, "partial_clr");
        step(1'b1, 1'b1, 1'b1, 4'd3, 1'b1, "clr_with_bit");
        send_vec(8'hA5, 1'b1, 4'd3, "after_clr");
        check_eq("after_clr.vec_const", 32'(act_vec), 32'hA5);
        check_eq("after_clr.ovf_const", 32'(overflow), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 1) == 1),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 2), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_activation_collector.md
BNN_ACTIVATION_COLLECTOR -- requirements
Module: bnn_activation_collector

Interface
REQ-001 Parameter N_BITS, default 8, number of neuron output bits packed per activation vector.
REQ-002 Parameter CNT_W, default 4, popcount/threshold width; SHALL equal clog2(N_BITS+1).
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 clear  input  1  synchronous flush of collection and output buffer.
REQ-006 bit_valid  input  1  bit_in is valid this cycle; driven from the upstream neuron stage.
REQ-007 bit_in  input  1  binarised neuron output (o_neuron).
REQ-008 thresh  input  CNT_W  decision threshold, 0..N_BITS.
REQ-009 out_valid  output  1  output buffer holds an unconsumed vector.
REQ-010 out_ready  input  1  downstream accepts the vector when out_valid && out_ready.
REQ-011 act_vec  output  N_BITS  packed activation vector.
REQ-012 popcount  output  CNT_W  number of ones in act_vec.
REQ-013 decision  output  1  1 when popcount >= thresh sampled at completion.
REQ-014 overflow  output  1  sticky; a valid bit was dropped.

Function
REQ-015 The first accepted bit of a vector SHALL land in act_vec[0]; bit k lands in act_vec[k].
REQ-016 A bit counter 0..N_BITS-1 SHALL advance on each accepted bit and wrap to 0 after the N_BITS-th bit.
REQ-017 FSM states: COLLECT (accepting bits), HOLD (vector complete, output buffer occupied, next vector not yet transferable).
REQ-018 In COLLECT, the N_BITS-th accepted bit SHALL complete the vector; if the buffer is empty or drains in the same cycle, the vector, popcount and decision SHALL load into the buffer at that edge; out_valid rises the next cycle (latency 1 cycle from last bit).
REQ-019 If the buffer is full and not draining when a vector completes, the completed vector SHALL be held in the shift register and the FSM SHALL enter HOLD.
REQ-020 In HOLD, bit_valid bits SHALL be dropped and overflow set to 1; on out_valid && out_ready, the held vector SHALL transfer into the buffer at the same edge and the FSM returns to COLLECT with count 0.
REQ-021 out_valid SHALL stay high and act_vec/popcount/decision stable until the handshake completes.
REQ-022 popcount SHALL be computed on the completed vector; decision SHALL compare it, unsigned, to thresh sampled at the completing edge; thresh=0 yields decision=1, thresh>N_BITS yields decision=0.
REQ-023 clear SHALL zero count, shift register, buffer, out_valid and overflow and force COLLECT; clear wins over simultaneous bit_valid or handshake.
REQ-024 bit_valid while out_valid && out_ready in COLLECT SHALL both be honoured in the same cycle.

Reset
REQ-025 rst SHALL asynchronously force COLLECT, count 0, shift register 0, out_valid 0, act_vec 0, popcount 0, decision 0, overflow 0.
REQ-026 Reset mid-vector SHALL discard partial bits; the first bit after release is act_vec[0].

Structure
REQ-027 Shared package bnn_pkg SHALL hold N_BITS, CNT_W defaults and the FSM state enum (COLLECT, HOLD).
REQ-028 Popcount SHALL live in a combinational sub-module bnn_popcount, parameterised by N_BITS.
REQ-029 No latches; all outputs driven from registers.

Verification
REQ-030 Reset release, bits 1,0,1,1,0,0,1,0 with thresh=4, out_ready=1 -> out_valid one cycle after 8th bit, act_vec=0x4D, popcount=4, decision=1.
REQ-031 Same with thresh=5 -> decision=0; thresh=0 with all-zero bits -> popcount=0, decision=1.
REQ-032 out_ready=0, two vectors 0xFF then 0x0F -> first held, FSM in HOLD, extra bit sets overflow; raise out_ready -> 0xFF consumed, 0x0F appears next cycle with popcount=4.
REQ-033 Back-to-back 16 bits, out_ready=1 continuous -> two vectors, no overflow, no lost bits.
REQ-034 Assert rst after 5 bits, release, send 8 bits 0xA5 -> act_vec=0xA5; repeat with clear instead of rst, clear coincident with bit_valid -> that bit dropped, overflow=0.
